// File: rtl/writeback_stage_if.sv
// Interface bundling the writeback stage's instruction-in, data-memory
// response and register-file write signals.
// Optional macro WB_BYPASS_EN adds the decode bypass signals
// fwd_valid/fwd_rd/fwd_data.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        write_enable;
  logic        retire;
  logic        load_fault;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  // memory stage / data memory / register file side
  modport master (
    output in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
           in_pc, in_funct3, dmem_rsp_valid, dmem_rsp_data,
    input  in_ready, addr_rd, data_rd, write_enable, retire, load_fault
`ifdef WB_BYPASS_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );

  // the writeback stage itself
  modport slave (
    input  in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
           in_pc, in_funct3, dmem_rsp_valid, dmem_rsp_data,
    output in_ready, addr_rd, data_rd, write_enable, retire, load_fault
`ifdef WB_BYPASS_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/writeback_stage.sv
// Final RISC-V pipeline stage: retires ALU / PC+4 results in one cycle,
// waits for data-memory responses on loads, aligns and sign/zero-extends
// the load data and drives a registered register-file write port.
// Optional macro WB_BYPASS_EN mirrors the write port onto fwd_* so decode
// can bypass the same-cycle register-file write/read hazard.
module writeback_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic           clock,
  input  logic           reset,
  writeback_stage_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic [4:0]  rd_q, rd_next;
  logic        reg_write_q, reg_write_next;
  logic [1:0]  off_q, off_next;
  logic [2:0]  funct3_q, funct3_next;

  logic [4:0]  addr_next;
  logic [31:0] data_next;
  logic        we_next;
  logic        retire_next;
  logic        fault_next;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic        ld_fault;

  // Pick the addressed byte/half of the response word and extend it;
  // flag unsupported widths and misaligned halfword/word accesses.
  always_comb begin
    ld_data  = '0;
    ld_fault = 1'b0;
    case (off_q)
      2'd0:    byte_sel = bus.dmem_rsp_data[7:0];
      2'd1:    byte_sel = bus.dmem_rsp_data[15:8];
      2'd2:    byte_sel = bus.dmem_rsp_data[23:16];
      default: byte_sel = bus.dmem_rsp_data[31:24];
    endcase
    half_sel = off_q[1] ? bus.dmem_rsp_data[31:16] : bus.dmem_rsp_data[15:0];
    case (funct3_q)
      3'b000: ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: ld_data = {24'h0, byte_sel};
      3'b001: begin
        ld_data  = {{16{half_sel[15]}}, half_sel};
        ld_fault = off_q[0];
      end
      3'b101: begin
        ld_data  = {16'h0, half_sel};
        ld_fault = off_q[0];
      end
      3'b010: begin
        ld_data  = bus.dmem_rsp_data;
        ld_fault = (off_q != 2'b00);
      end
      default: ld_fault = 1'b1;
    endcase
  end

  // Next-state and next-output logic; outputs default to an idle cycle
  // with the write port holding its last address/data.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    rd_next        = rd_q;
    reg_write_next = reg_write_q;
    off_next       = off_q;
    funct3_next    = funct3_q;
    we_next        = 1'b0;
    retire_next    = 1'b0;
    fault_next     = 1'b0;
    addr_next      = bus.addr_rd;
    data_next      = bus.data_rd;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          rd_next        = bus.in_rd;
          reg_write_next = bus.in_reg_write;
          off_next       = bus.in_alu_result[1:0];
          funct3_next    = bus.in_funct3;
          if (bus.in_wb_sel == 2'b01) begin
            state_next    = WAIT_LOAD;
            wait_cnt_next = 8'd0;
          end else begin
            retire_next = 1'b1;
            we_next     = bus.in_reg_write && (bus.in_rd != 5'd0) &&
                          (bus.in_wb_sel != 2'b11);
            if (we_next) begin
              addr_next = bus.in_rd;
              data_next = (bus.in_wb_sel == 2'b10) ? bus.in_pc + 32'd4
                                                   : bus.in_alu_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (bus.dmem_rsp_valid) begin
          state_next = IDLE;
          if (ld_fault) begin
            fault_next = 1'b1;
          end else begin
            retire_next = 1'b1;
            we_next     = reg_write_q && (rd_q != 5'd0);
            if (we_next) begin
              addr_next = rd_q;
              data_next = ld_data;
            end
          end
        end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
          fault_next = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
    endcase
  end

  // State, latched instruction fields and registered write-port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      rd_q             <= 5'd0;
      reg_write_q      <= 1'b0;
      off_q            <= 2'd0;
      funct3_q         <= 3'd0;
      bus.addr_rd      <= 5'd0;
      bus.data_rd      <= 32'd0;
      bus.write_enable <= 1'b0;
      bus.retire       <= 1'b0;
      bus.load_fault   <= 1'b0;
    end else begin
      state            <= state_next;
      wait_cnt         <= wait_cnt_next;
      rd_q             <= rd_next;
      reg_write_q      <= reg_write_next;
      off_q            <= off_next;
      funct3_q         <= funct3_next;
      bus.addr_rd      <= addr_next;
      bus.data_rd      <= data_next;
      bus.write_enable <= we_next;
      bus.retire       <= retire_next;
      bus.load_fault   <= fault_next;
    end
  end

  assign bus.in_ready = (state == IDLE);

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = bus.write_enable;
  assign bus.fwd_rd    = bus.addr_rd;
  assign bus.fwd_data  = bus.data_rd;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed instructions are turned
// into a per-cycle timeline of expected outputs that a compare process
// checks on every falling edge, plus literal spot checks.
module tb_writeback_stage;

  localparam int NCYC = 2048;

  logic clock = 1'b0;
  logic reset;

  writeback_stage_if bus();

  writeback_stage #(.MAX_WAIT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit checking     = 1'b0;

  bit          exp_we   [NCYC];
  bit          exp_ret  [NCYC];
  bit          exp_flt  [NCYC];
  bit          exp_busy [NCYC];
  logic [4:0]  exp_addr [NCYC];
  logic [31:0] exp_data [NCYC];

  // cycle index advances on every rising edge
  always @(posedge clock) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // load result straight from the ISA rules
  function automatic void model_load(input logic [2:0] f3, input logic [1:0] off,
                                     input logic [31:0] word,
                                     output logic [31:0] val, output bit fault);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (off >= 2'd2) ? (word >> 16) : (word & 32'hFFFF);
    val   = 32'd0;
    fault = 1'b0;
    case (f3)
      3'b000: val = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100: val = b;
      3'b001: begin val = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h; fault = (off % 2) != 0; end
      3'b101: begin val = h; fault = (off % 2) != 0; end
      3'b010: begin val = word; fault = (off != 2'd0); end
      default: fault = 1'b1;
    endcase
  endfunction

  task automatic expect_at(input int c, input bit we, input bit ret, input bit flt,
                           input logic [4:0] a, input logic [31:0] d);
    exp_we[c]   = we;
    exp_ret[c]  = ret;
    exp_flt[c]  = flt;
    exp_addr[c] = a;
    exp_data[c] = d;
  endtask

  // Issue one instruction; loads get their response 'delay' cycles after
  // acceptance (delay 0 = never respond). Returns #1 after the edge that
  // produced the result, with the stage idle again.
  task automatic applyStimulus(input logic [4:0] rd, input bit rw, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] pc,
                               input logic [2:0] f3, input logic [31:0] rsp,
                               input int delay);
    int a;
    logic [31:0] v;
    bit f, we;
    a = cyc + 1;
    if (sel != 2'b01) begin
      v  = (sel == 2'b10) ? pc + 32'd4 : alu;
      we = rw && (rd != 5'd0) && (sel != 2'b11);
      expect_at(a, we, 1'b1, 1'b0, rd, v);
    end else if (delay == 0) begin
      for (int k = 0; k < 15; k++) exp_busy[a + k] = 1'b1;
      expect_at(a + 15, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);
    end else begin
      for (int k = 0; k < delay; k++) exp_busy[a + k] = 1'b1;
      model_load(f3, alu[1:0], rsp, v, f);
      we = rw && (rd != 5'd0) && !f;
      expect_at(a + delay, we, !f, f, rd, v);
    end
    bus.in_valid      = 1'b1;
    bus.in_rd         = rd;
    bus.in_reg_write  = rw;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc         = pc;
    bus.in_funct3     = f3;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    if (sel == 2'b01) begin
      if (delay == 0) begin
        repeat (15) begin @(posedge clock); #1; end
      end else begin
        repeat (delay - 1) begin @(posedge clock); #1; end
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rsp_data  = rsp;
        @(posedge clock); #1;
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rsp_data  = 32'h0;
      end
    end
  endtask

  // compare process: every cycle against the expected timeline
  always @(negedge clock) begin
    if (checking && cyc < NCYC) begin
      checkOutput("write_enable", {31'd0, bus.write_enable}, {31'd0, exp_we[cyc]});
      checkOutput("retire", {31'd0, bus.retire}, {31'd0, exp_ret[cyc]});
      checkOutput("load_fault", {31'd0, bus.load_fault}, {31'd0, exp_flt[cyc]});
      checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, !exp_busy[cyc]});
      if (exp_we[cyc]) begin
        checkOutput("addr_rd", {27'd0, bus.addr_rd}, {27'd0, exp_addr[cyc]});
        checkOutput("data_rd", bus.data_rd, exp_data[cyc]);
      end
`ifdef WB_BYPASS_EN
      checkOutput("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, exp_we[cyc]});
      if (exp_we[cyc]) checkOutput("fwd_data", bus.fwd_data, exp_data[cyc]);
`endif
    end
  end

  // watchdog
  initial begin
    #200000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_rd          = 5'd0;
    bus.in_reg_write   = 1'b0;
    bus.in_wb_sel      = 2'b00;
    bus.in_alu_result  = 32'h0;
    bus.in_pc          = 32'h0;
    bus.in_funct3      = 3'b000;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_data  = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_write_enable", {31'd0, bus.write_enable}, 32'd0);
    checkOutput("rst_retire", {31'd0, bus.retire}, 32'd0);
    checkOutput("rst_load_fault", {31'd0, bus.load_fault}, 32'd0);
    checkOutput("rst_data_rd", bus.data_rd, 32'd0);
    reset    = 1'b0;
    checking = 1'b1;
    @(posedge clock); #1;

    // ALU op
    applyStimulus(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 32'h0, 0);
    checkOutput("alu_data_lit", bus.data_rd, 32'h1234_5678);
    checkOutput("alu_addr_lit", {27'd0, bus.addr_rd}, 32'd5);
    checkOutput("alu_retire_lit", {31'd0, bus.retire}, 32'd1);
    // JAL wraparound
    applyStimulus(5'd1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 3'b000, 32'h0, 0);
    checkOutput("jal_data_lit", bus.data_rd, 32'h0000_0000);
    checkOutput("jal_we_lit", {31'd0, bus.write_enable}, 32'd1);
    // back-to-back
    applyStimulus(5'd7, 1'b1, 2'b00, 32'hA5A5_0001, 32'h0, 3'b000, 32'h0, 0);
    applyStimulus(5'd8, 1'b1, 2'b10, 32'h0, 32'h0000_0100, 3'b000, 32'h0, 0);
    checkOutput("b2b_data_lit", bus.data_rd, 32'h0000_0104);
    // rd = 0, reg_write = 0, reserved wb_sel
    applyStimulus(5'd0, 1'b1, 2'b00, 32'hDEAD_0000, 32'h0, 3'b000, 32'h0, 0);
    checkOutput("rd0_we_lit", {31'd0, bus.write_enable}, 32'd0);
    checkOutput("rd0_retire_lit", {31'd0, bus.retire}, 32'd1);
    applyStimulus(5'd9, 1'b0, 2'b00, 32'h1111_1111, 32'h0, 3'b000, 32'h0, 0);
    applyStimulus(5'd9, 1'b1, 2'b11, 32'h2222_2222, 32'h0, 3'b000, 32'h0, 0);
    // response while idle must be ignored
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_data  = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bus.dmem_rsp_valid = 1'b0;
    @(posedge clock); #1;

    // loads
    applyStimulus(5'd3, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'b000, 32'h80FF_0000, 3);
    checkOutput("lb_data_lit", bus.data_rd, 32'hFFFF_FF80);
    applyStimulus(5'd4, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'b100, 32'h80FF_0000, 3);
    checkOutput("lbu_data_lit", bus.data_rd, 32'h0000_0080);
    applyStimulus(5'd6, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 3'b001, 32'h8001_7FFF, 1);
    checkOutput("lh_data_lit", bus.data_rd, 32'hFFFF_8001);
    applyStimulus(5'd6, 1'b1, 2'b01, 32'h0000_2000, 32'h0, 3'b101, 32'h8001_FFFE, 2);
    checkOutput("lhu_data_lit", bus.data_rd, 32'h0000_FFFE);
    applyStimulus(5'd11, 1'b1, 2'b01, 32'h0000_3001, 32'h0, 3'b000, 32'h0000_7F00, 1);
    applyStimulus(5'd12, 1'b1, 2'b01, 32'h0000_3000, 32'h0, 3'b010, 32'hDEAD_BEEF, 2);
    checkOutput("lw_data_lit", bus.data_rd, 32'hDEAD_BEEF);
    applyStimulus(5'd0, 1'b1, 2'b01, 32'h0000_3000, 32'h0, 3'b010, 32'h1234_4321, 1);

    // faults
    applyStimulus(5'd13, 1'b1, 2'b01, 32'h0000_4002, 32'h0, 3'b010, 32'h5555_5555, 2);
    checkOutput("lw_mis_fault_lit", {31'd0, bus.load_fault}, 32'd1);
    checkOutput("lw_mis_we_lit", {31'd0, bus.write_enable}, 32'd0);
    checkOutput("lw_mis_retire_lit", {31'd0, bus.retire}, 32'd0);
    checkOutput("lw_mis_ready_lit", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(5'd14, 1'b1, 2'b01, 32'h0000_4001, 32'h0, 3'b001, 32'h5555_5555, 1);
    applyStimulus(5'd15, 1'b1, 2'b01, 32'h0000_4000, 32'h0, 3'b011, 32'h5555_5555, 1);
    applyStimulus(5'd16, 1'b1, 2'b01, 32'h0000_4000, 32'h0, 3'b110, 32'h5555_5555, 1);
    // timeout
    applyStimulus(5'd17, 1'b1, 2'b01, 32'h0000_5000, 32'h0, 3'b010, 32'h0, 0);
    checkOutput("timeout_fault_lit", {31'd0, bus.load_fault}, 32'd1);
    applyStimulus(5'd18, 1'b1, 2'b00, 32'h0BAD_F00D, 32'h0, 3'b000, 32'h0, 0);

    // reset during a load, then a late response
    a = cyc + 1;
    exp_busy[a] = 1'b1;
    bus.in_valid      = 1'b1;
    bus.in_rd         = 5'd19;
    bus.in_reg_write  = 1'b1;
    bus.in_wb_sel     = 2'b01;
    bus.in_alu_result = 32'h0000_6000;
    bus.in_funct3     = 3'b010;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ready_lit", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_data  = 32'h7777_7777;
    @(posedge clock); #1;
    bus.dmem_rsp_valid = 1'b0;
    checkOutput("midrst_we_lit", {31'd0, bus.write_enable}, 32'd0);
    @(posedge clock); #1;
    applyStimulus(5'd20, 1'b1, 2'b00, 32'h0000_00AA, 32'h0, 3'b000, 32'h0, 0);
    checkOutput("post_rst_data_lit", bus.data_rd, 32'h0000_00AA);

    repeat (3) begin @(posedge clock); #1; end
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
